// File: rtl/commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : commit_ctrl
// Purpose  : In-order retirement sequencer between ROB head and register file;
//            handles store handshake, mispredict flush sequencing and halt.
// Revision : 1.0
// ============================================================================
module commit_ctrl #(
    parameter int ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               head_valid,
    input  logic               head_ready,
    input  logic [1:0]         head_type,
    input  logic               head_has_dest,
    input  logic [4:0]         head_dest,
    input  logic [31:0]        head_value,
    input  logic [ROB_LOG-1:0] head_robid,
    input  logic               head_mispredict,
    input  logic [31:0]        head_target_pc,
    output logic               rob_pop,
    output logic               commit_valid,
    output logic [4:0]         commit_dest,
    output logic [31:0]        commit_value,
    output logic [ROB_LOG-1:0] commit_RobId,
    output logic               store_req,
    input  logic               store_ack,
    output logic               jump_flag,
    output logic [31:0]        jump_pc,
    output logic               halted,
    output logic [31:0]        commit_cnt
);

    localparam logic [1:0] c_TYPE_REG    = 2'd0;
    localparam logic [1:0] c_TYPE_STORE  = 2'd1;
    localparam logic [1:0] c_TYPE_BRANCH = 2'd2;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_WAIT_ST = 3'd1,
        S_FLUSH   = 3'd2,
        S_DRAIN   = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_pop;
    logic               w_commit;
    logic               w_jump;
    logic               w_halt;
    logic               w_store_set;
    logic               w_store_clr;
    logic               w_mispredict;

    logic               r_commit_valid;
    logic [4:0]         r_commit_dest;
    logic [31:0]        r_commit_value;
    logic [ROB_LOG-1:0] r_commit_robid;
    logic               r_store_req;
    logic               r_jump_flag;
    logic [31:0]        r_jump_pc;
    logic               r_halted;
    logic [31:0]        r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // With rdy low every enable stays 0 and the state holds.
    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_commit     = 1'b0;
        w_jump       = 1'b0;
        w_halt       = 1'b0;
        w_store_set  = 1'b0;
        w_store_clr  = 1'b0;
        w_mispredict = 1'b0;
        if (rdy) begin
            case (r_state)
                S_RUN: begin
                    if (head_valid && head_ready) begin
                        case (head_type)
                            c_TYPE_REG: begin
                                w_pop    = 1'b1;
                                w_commit = 1'b1;
                            end
                            c_TYPE_STORE: begin
                                w_store_set = 1'b1;
                                w_next      = S_WAIT_ST;
                            end
                            c_TYPE_BRANCH: begin
                                w_pop    = 1'b1;
                                w_commit = 1'b1;
                                if (head_mispredict) begin
                                    w_mispredict = 1'b1;
                                    w_next       = S_FLUSH;
                                end
                            end
                            default: begin
                                w_pop  = 1'b1;
                                w_halt = 1'b1;
                                w_next = S_HALT;
                            end
                        endcase
                    end
                end
                S_WAIT_ST: begin
                    if (store_ack) begin
                        w_pop       = 1'b1;
                        w_store_clr = 1'b1;
                        w_next      = S_RUN;
                    end
                end
                S_FLUSH: begin
                    w_jump = 1'b1;
                    w_next = S_DRAIN;
                end
                S_DRAIN: begin
                    w_next = S_RUN;
                end
                S_HALT: begin
                    w_next = S_HALT;
                end
                default: begin
                    w_next = S_RUN;
                end
            endcase
        end
    end

    assign rob_pop = w_pop & rst;

    // Redirect PC is captured at the branch pop; the head is stale by FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commit_valid <= 1'b0;
            r_commit_dest  <= 5'd0;
            r_commit_value <= 32'd0;
            r_commit_robid <= '0;
            r_store_req    <= 1'b0;
            r_jump_flag    <= 1'b0;
            r_jump_pc      <= 32'd0;
            r_halted       <= 1'b0;
            r_cnt          <= 32'd0;
        end else begin
            r_commit_valid <= w_commit & head_has_dest & (|head_dest);
            r_jump_flag    <= w_jump;
            if (w_commit) begin
                r_commit_dest  <= head_dest;
                r_commit_value <= head_value;
                r_commit_robid <= head_robid;
            end
            if (w_mispredict) begin
                r_jump_pc <= head_target_pc;
            end
            if (w_store_set) begin
                r_store_req <= 1'b1;
            end else if (w_store_clr) begin
                r_store_req <= 1'b0;
            end
            if (w_halt) begin
                r_halted <= 1'b1;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_dest  = r_commit_dest;
    assign commit_value = r_commit_value;
    assign commit_RobId = r_commit_robid;
    assign store_req    = r_store_req;
    assign jump_flag    = r_jump_flag;
    assign jump_pc      = r_jump_pc;
    assign halted       = r_halted;
    assign commit_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Retirement sequencer between the reorder buffer head and the architectural register file.
- Each cycle it inspects the ROB head entry and retires at most one entry in program order:
  - drives the register-file commit port for register writes;
  - handshakes with the load/store buffer for stores;
  - sequences the mispredict flush (`jump_flag`) so that a link-register write is never lost to the flush;
  - latches halt.

Parameters:
- ROB_LOG, 4, width of ROB index. Index 0 is reserved as the "no rename" tag, so valid RobIds are 1..2^ROB_LOG-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global ready; when 0 the block stalls
- head_valid  input  1  ROB non-empty
- head_ready  input  1  head entry result available
- head_type  input  2  0=REG, 1=STORE, 2=BRANCH, 3=HALT
- head_has_dest  input  1  entry writes rd (REG, JAL/JALR link)
- head_dest  input  5  rd
- head_value  input  32  result / link value
- head_robid  input  ROB_LOG  RobId of head
- head_mispredict  input  1  BRANCH resolved opposite to prediction
- head_target_pc  input  32  correct PC after mispredict
- rob_pop  output  1  combinational; advance ROB head this cycle
- commit_valid  output  1  register-file commit strobe
- commit_dest  output  5  commit rd
- commit_value  output  32  commit data
- commit_RobId  output  ROB_LOG  commit tag
- store_req  output  1  request LSB to perform head store
- store_ack  input  1  LSB store done (one-cycle pulse)
- jump_flag  output  1  flush pulse to ROB/RS/LSB/RegFile/IF
- jump_pc  output  32  redirect PC, valid with jump_flag
- halted  output  1  sticky halt indication
- commit_cnt  output  32  retired-instruction counter

Behaviour:
- Reset (rst=0, async):
  - State enters RUN.
  - All registered outputs are 0; commit_cnt is 0.
  - rob_pop is 0 while in reset.
- States: RUN, WAIT_ST, FLUSH, DRAIN, HALT.
- rdy=0:
  - State, counter and commit_* registers hold.
  - rob_pop is forced 0.
  - commit_valid and jump_flag are forced 0 on the next edge.
  - store_req holds its value.
- A retire in cycle t: rob_pop=1 in t, commit_cnt+1 at the end of t.
- Pulse outputs (commit_valid, jump_flag) are high for exactly one cycle and default to 0 otherwise.
- RUN, when head_valid && head_ready:
  - REG: rob_pop=1. commit_valid=head_has_dest in t+1, with dest/value/RobId registered from t. Stay in RUN, so back-to-back retires at 1 per cycle are possible.
  - STORE: no pop. store_req=1 from t+1; go to WAIT_ST.
  - BRANCH, not mispredicted: same as REG.
  - BRANCH, mispredicted: rob_pop=1; commit as for REG in t+1; go to FLUSH.
  - HALT: rob_pop=1; go to HALT.
- RUN, when head_valid=0 or head_ready=0: no action.
- WAIT_ST:
  - rob_pop=0 while waiting.
  - When store_ack=1: rob_pop=1 that cycle, store_req=0 next cycle, commit_cnt+1; go to RUN.
  - No commit_valid is generated for stores.
- FLUSH (t+1): rob_pop=0. jump_flag=1 and jump_pc=target are registered, visible in t+2. Go to DRAIN.
  - Ordering rule: the link commit (t+1) strictly precedes jump_flag (t+2).
- DRAIN (t+2): jump_flag is high; rob_pop=0 regardless of head (head is stale). Go to RUN at t+3.
- HALT:
  - halted=1 from the cycle after entry, sticky until rst.
  - No further pops, commits or store requests.
- commit_cnt: wraps at 2^32.
- Reset mid-operation (e.g. in WAIT_ST or FLUSH): store_req and jump_flag drop immediately and asynchronously.

Test Plan:
- REG burst: heads robid 1,2,3 (dest 5,6,0; values 0x11,0x22,0x33), all ready.
  -> rob_pop high for 3 consecutive cycles.
  -> commit_valid for robid 1 (rd 5, 0x11) and robid 2 (rd 6, 0x22) on the following 2 consecutive cycles; no commit_valid for robid 3 (rd 0); commit_cnt=3.
- Store: head STORE ready; store_ack held 0 for 4 cycles, then pulsed.
  -> store_req high from t+1 until the ack cycle, cleared the cycle after.
  -> single rob_pop in the ack cycle; commit_cnt+1; no commit_valid.
- Mispredict JAL: BRANCH with mispredict, has_dest, rd=1, value=0x1004, target=0x2000 at cycle t.
  -> rob_pop in t; commit_valid rd=1/0x1004 in t+1.
  -> jump_flag=1 with jump_pc=0x2000 in t+2 only.
  -> no pop in t+1 or t+2 even with head_valid=1; retire resumes at t+3.
- rdy stall: drop rdy for 3 cycles mid REG burst.
  -> no pops and no pulses during the stall; the sequence resumes with no lost or duplicated commit.
- HALT: HALT head.
  -> halted=1 next cycle and stays 1; later REG heads are never popped.
- Async reset in WAIT_ST: assert rst=0 between clock edges.
  -> store_req=0, state RUN, commit_cnt=0 immediately, without waiting for a clock edge.
